// File: rtl/avst_sum_param.sv
// avst_sum_param: Avalon-ST packet summer; emits the SUM_BEATS*DATA_W-bit sum as SUM_BEATS beats, LSB beat first.
// Define AVST_SUM_SAT_EN to make the accumulator saturate at all-ones instead of wrapping.
module avst_sum_param #(
    parameter int DATA_W    = 8,
    parameter int SUM_BEATS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              end_out,
    input  logic              ready_out
);
    localparam int SUM_W = DATA_W * SUM_BEATS;
    localparam int IDX_W = (SUM_BEATS > 1) ? $clog2(SUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUM_BEATS - 1);

    typedef enum logic {
        ACC,
        EMIT
    } state_t;

    state_t            state, state_next;
    logic [SUM_W-1:0]  acc, acc_next;
    logic [SUM_W-1:0]  shreg, shreg_next;
    logic [SUM_W-1:0]  sum, shifted;
    logic [IDX_W-1:0]  idx, idx_next, idx_inc;
    logic [DATA_W-1:0] data_out_next;
    logic              ready_in_next, valid_out_next, end_out_next;
    logic              in_xfer, out_xfer;

    assign in_xfer  = valid_in && ready_in;
    assign out_xfer = valid_out && ready_out;
    assign shifted  = shreg >> DATA_W;
    assign idx_inc  = idx + 1'b1;

`ifdef AVST_SUM_SAT_EN
    // Once saturated, adding any further beat keeps the carry set, so acc stays all-ones.
    logic [SUM_W:0] sum_ext;
    assign sum_ext = {1'b0, acc} + (SUM_W + 1)'(data_in);
    assign sum     = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`else
    assign sum = acc + SUM_W'(data_in);
`endif

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        shreg_next     = shreg;
        idx_next       = idx;
        ready_in_next  = ready_in;
        valid_out_next = valid_out;
        end_out_next   = end_out;
        data_out_next  = data_out;
        case (state)
            ACC: begin
                ready_in_next = 1'b1;
                if (in_xfer) begin
                    if (end_in) begin
                        shreg_next     = sum;
                        acc_next       = '0;
                        idx_next       = '0;
                        data_out_next  = sum[DATA_W-1:0];
                        valid_out_next = 1'b1;
                        end_out_next   = (LAST_IDX == '0);
                        ready_in_next  = 1'b0;
                        state_next     = EMIT;
                    end else begin
                        acc_next = sum;
                    end
                end
            end
            EMIT: begin
                ready_in_next = 1'b0;
                // Output registers only move on a transfer, which gives hold-stable backpressure.
                if (out_xfer) begin
                    if (end_out) begin
                        valid_out_next = 1'b0;
                        end_out_next   = 1'b0;
                        data_out_next  = '0;
                        shreg_next     = '0;
                        idx_next       = '0;
                        ready_in_next  = 1'b1;
                        state_next     = ACC;
                    end else begin
                        shreg_next    = shifted;
                        data_out_next = shifted[DATA_W-1:0];
                        idx_next      = idx_inc;
                        end_out_next  = (idx_inc == LAST_IDX);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            acc       <= '0;
            shreg     <= '0;
            idx       <= '0;
            ready_in  <= 1'b0;
            valid_out <= 1'b0;
            end_out   <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            shreg     <= shreg_next;
            idx       <= idx_next;
            ready_in  <= ready_in_next;
            valid_out <= valid_out_next;
            end_out   <= end_out_next;
            data_out  <= data_out_next;
        end
    end

endmodule
